// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, default instruction words and
// a saturating counter helper.
package if_stage_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NopInstrDefault  = 32'h0000_0000;
  localparam logic [31:0] HaltInstrDefault = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// Pipeline register {valid, pc, pc4, instr} with load / hold / flush control.
// Flush wins over load; a flush keeps the pc fields and only kills valid and instr.
module if_stage_if_id_reg #(
  parameter int unsigned    W         = 32,
  parameter logic [W-1:0]   NOP_INSTR = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] pc4_i,
  input  logic [W-1:0] instr_i,
  output logic         valid_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc4_o,
  output logic [W-1:0] instr_o
);

  logic         valid_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] pc4_q;
  logic [W-1:0] instr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, +4 adder, redirect/stall handling, boot/run/halt FSM,
// sticky misalign flag and saturating activity counters feeding the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned  W          = 32,
  parameter logic [W-1:0] RESET_PC   = '0,
  parameter logic [W-1:0] NOP_INSTR  = W'(NopInstrDefault),
  parameter logic [W-1:0] HALT_INSTR = W'(HaltInstrDefault)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic [W-1:0] imem_addr_o,
  input  logic [W-1:0] imem_rdata_i,
  input  logic         stall_i,
  input  logic         redirect_valid_i,
  input  logic [W-1:0] redirect_pc_i,
  output logic         if_id_valid_o,
  output logic [W-1:0] if_id_pc_o,
  output logic [W-1:0] if_id_pc4_o,
  output logic [W-1:0] if_id_instr_o,
  output logic         halted_o,
  output logic         misalign_o,
  output logic [31:0]  fetch_count_o,
  output logic [31:0]  stall_count_o
);

  fetch_state_e state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;
  logic [31:0]  stall_cnt_q, stall_cnt_d;
  logic [W-1:0] pc_plus4;
  logic [W-1:0] redirect_pc_aligned;
  logic         redirect_misaligned;
  logic         ifid_load;
  logic         ifid_flush;

  assign pc_plus4            = pc_q + W'(4);
  assign redirect_pc_aligned = {redirect_pc_i[W-1:2], 2'b00};
  assign redirect_misaligned = |redirect_pc_i[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (redirect_valid_i) begin
          pc_d       = redirect_pc_aligned;
          ifid_flush = 1'b1;
          misalign_d = misalign_q | redirect_misaligned;
        end else if (stall_i) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          pc_d        = pc_plus4;
          ifid_load   = 1'b1;
          fetch_cnt_d = sat_inc(fetch_cnt_q);
          if (imem_rdata_i == HALT_INSTR) state_d = StHalt;
        end
      end
      StHalt: begin
        // An older branch resolving in EX overrides the halt.
        if (redirect_valid_i) begin
          state_d    = StRun;
          pc_d       = redirect_pc_aligned;
          ifid_flush = 1'b1;
          misalign_d = misalign_q | redirect_misaligned;
        end else if (!stall_i) begin
          ifid_flush = 1'b1;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  if_stage_if_id_reg #(
    .W         (W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .instr_i (imem_rdata_i),
    .valid_o (if_id_valid_o),
    .pc_o    (if_id_pc_o),
    .pc4_o   (if_id_pc4_o),
    .instr_o (if_id_instr_o)
  );

  assign imem_addr_o   = pc_q;
  assign halted_o      = (state_q == StHalt);
  assign misalign_o    = misalign_q;
  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural fetch model checked every cycle, plus literal checkpoints
// and a second instance with the reset PC at the top of the address space.
module tb_if_stage;

  localparam logic [31:0] Nop  = 32'h0000_0000;
  localparam logic [31:0] Halt = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  logic [31:0] halt_addr;

  logic [31:0] addr, rdata, ipc, ipc4, instr, fcnt, scnt;
  logic        ivalid, halted, misalign;
  logic [31:0] addr2, rdata2, ipc2, ipc42, instr2, fcnt2, scnt2;
  logic        ivalid2, halted2, misalign2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return Halt;
    return 32'h1300_0000 | a;
  endfunction

  assign rdata  = mem_word(addr);
  assign rdata2 = mem_word(addr2);

  if_stage #(
    .W          (32),
    .RESET_PC   (32'h0000_0000),
    .NOP_INSTR  (Nop),
    .HALT_INSTR (Halt)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_addr_o      (addr),
    .imem_rdata_i     (rdata),
    .stall_i          (stall),
    .redirect_valid_i (redir),
    .redirect_pc_i    (rpc),
    .if_id_valid_o    (ivalid),
    .if_id_pc_o       (ipc),
    .if_id_pc4_o      (ipc4),
    .if_id_instr_o    (instr),
    .halted_o         (halted),
    .misalign_o       (misalign),
    .fetch_count_o    (fcnt),
    .stall_count_o    (scnt)
  );

  if_stage #(
    .W          (32),
    .RESET_PC   (32'hFFFF_FFFC),
    .NOP_INSTR  (Nop),
    .HALT_INSTR (Halt)
  ) dut_top (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_addr_o      (addr2),
    .imem_rdata_i     (rdata2),
    .stall_i          (stall),
    .redirect_valid_i (redir),
    .redirect_pc_i    (rpc),
    .if_id_valid_o    (ivalid2),
    .if_id_pc_o       (ipc2),
    .if_id_pc4_o      (ipc42),
    .if_id_instr_o    (instr2),
    .halted_o         (halted2),
    .misalign_o       (misalign2),
    .fetch_count_o    (fcnt2),
    .stall_count_o    (scnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage must hold after each edge.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_fc, m_sc;
  logic        m_v, m_boot, m_halt, m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_boot <= 1'b1; m_halt <= 1'b0; m_v <= 1'b0; m_mis <= 1'b0;
      m_ipc <= 32'h0; m_ipc4 <= 32'h0; m_instr <= Nop; m_fc <= 32'h0; m_sc <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (redir) begin
      m_pc    <= rpc & ~32'h3;
      m_v     <= 1'b0;
      m_instr <= Nop;
      m_mis   <= m_mis | (rpc[1:0] != 2'b00);
      m_halt  <= 1'b0;
    end else if (stall) begin
      if (!m_halt && m_sc != 32'hFFFF_FFFF) m_sc <= m_sc + 1;
    end else if (m_halt) begin
      m_v     <= 1'b0;
      m_instr <= Nop;
    end else begin
      m_ipc   <= m_pc;
      m_ipc4  <= m_pc + 4;
      m_instr <= mem_word(m_pc);
      m_v     <= 1'b1;
      m_pc    <= m_pc + 4;
      if (m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
      if (mem_word(m_pc) == Halt) m_halt <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("imem_addr", addr, m_pc);
    chk("if_id_valid", {31'b0, ivalid}, {31'b0, m_v});
    chk("if_id_pc", ipc, m_ipc);
    chk("if_id_pc4", ipc4, m_ipc4);
    chk("if_id_instr", instr, m_instr);
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("fetch_count", fcnt, m_fc);
    chk("stall_count", scnt, m_sc);
  end

  // Apply one cycle of inputs; returns #1 after the edge that consumed them.
  task automatic step(input logic s, input logic r, input logic [31:0] p);
    stall = s;
    redir = r;
    rpc   = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0; halt_addr = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("lit reset addr", addr, 32'h0);
    chk("lit reset instr", instr, Nop);
    chk("lit top reset addr", addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 32'h0);                     // boot cycle
    chk("lit boot valid", {31'b0, ivalid}, 32'h0);
    chk("lit boot addr", addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);                     // fetch 0x0
    chk("lit top wrap addr", addr2, 32'h0);
    chk("lit top wrap pc", ipc2, 32'hFFFF_FFFC);
    chk("lit top wrap pc4", ipc42, 32'h0);
    step(1'b0, 1'b0, 32'h0);                     // fetch 0x4
    chk("lit pc 4", ipc, 32'h4);
    chk("lit pc4 8", ipc4, 32'h8);

    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("lit stall addr", addr, 32'h8);
    chk("lit stall ifid pc", ipc, 32'h4);
    chk("lit stall_count", scnt, 32'd2);
    chk("lit stall fetch_count", fcnt, 32'd2);

    step(1'b1, 1'b1, 32'h40);                    // redirect beats stall
    chk("lit redir addr", addr, 32'h40);
    chk("lit redir valid", {31'b0, ivalid}, 32'h0);
    chk("lit redir instr", instr, Nop);
    chk("lit redir stall_count", scnt, 32'd2);
    step(1'b0, 1'b0, 32'h0);
    chk("lit post redir pc", ipc, 32'h40);

    step(1'b0, 1'b1, 32'h43);
    chk("lit misalign addr", addr, 32'h40);
    chk("lit misalign set", {31'b0, misalign}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h8);
    step(1'b0, 1'b0, 32'h0);                     // fetch 0x8
    step(1'b0, 1'b0, 32'h0);                     // fetch 0xC
    step(1'b0, 1'b0, 32'h0);                     // fetch 0x10 = halt word
    chk("lit halt instr", instr, 32'hFFFF_FFFF);
    chk("lit halted", {31'b0, halted}, 32'h1);
    chk("lit halt addr", addr, 32'h14);
    step(1'b0, 1'b0, 32'h0);
    chk("lit halt bubble", {31'b0, ivalid}, 32'h0);
    chk("lit halt hold addr", addr, 32'h14);
    step(1'b1, 1'b0, 32'h0);
    chk("lit halt stall uncounted", scnt, 32'd2);
    step(1'b0, 1'b1, 32'h20);
    chk("lit resume halted", {31'b0, halted}, 32'h0);
    chk("lit resume addr", addr, 32'h20);
    step(1'b0, 1'b0, 32'h0);
    chk("lit resume pc", ipc, 32'h20);
    chk("lit misalign sticky", {31'b0, misalign}, 32'h1);
    step(1'b1, 1'b0, 32'h0);

    rst_n = 1'b0;                                // mid-stall, mid-cycle
    #2;
    chk("lit async addr", addr, 32'h0);
    chk("lit async valid", {31'b0, ivalid}, 32'h0);
    chk("lit async misalign", {31'b0, misalign}, 32'h0);
    chk("lit async fetch_count", fcnt, 32'h0);
    chk("lit async stall_count", scnt, 32'h0);
    chk("lit async top addr", addr2, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("lit after reset pc", ipc, 32'h4);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
